load_store_unit: RTL and testbench

Memory-side stage between the 3-stage datapath's execute/writeback logic and the data memory (dmem). Accepts one load or store request at a time, generates word addresses and byte write-enables, merges and sign/zero-extends load data for LB/LBU/LH/LHU/LW, and optionally splits misaligned accesses into two word transactions. Drives a single-port dmem with one-cycle synchronous read latency.

---
 rtl/load_store_unit.sv | 208 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: dmem-side load/store stage with byte lanes and load extension.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses.
module load_store_unit #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [2:0]            req_bytes;
    logic                  req_mis;
    logic                  req_bad;
    logic [3:0]            mask4;
    logic [3:0]            we_lo;
    logic [31:0]           lane_lo;
    logic [31:0]           ld_word;
    logic [31:0]           ld_ext;
    logic                  unused_addr;
`ifdef MISALIGN_SPLIT_EN
    logic                  mis_q, mis_d;
    logic [31:0]           word0_q, word0_d;
    logic [63:0]           lane64;
    logic [63:0]           ld_pair;
    logic [7:0]            mask8;
    logic [3:0]            we_hi;
    logic [31:0]           lane_hi;
`endif

    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        unique case (req_size)
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
        req_mis = ({1'b0, req_addr[1:0]} + req_bytes) > 3'd4;
`ifdef MISALIGN_SPLIT_EN
        req_bad = (req_size == 2'b11);
`else
        req_bad = (req_size == 2'b11) || req_mis;
`endif
    end

    always_comb begin
        unique case (size_q)
            2'b00:   mask4 = 4'b0001;
            2'b01:   mask4 = 4'b0011;
            default: mask4 = 4'b1111;
        endcase
`ifdef MISALIGN_SPLIT_EN
        lane64  = {32'b0, wdata_q} << {off_q, 3'b000};
        mask8   = {4'b0, mask4} << off_q;
        lane_lo = lane64[31:0];
        lane_hi = lane64[63:32];
        we_lo   = mask8[3:0];
        we_hi   = mask8[7:4];
        // Split loads see word A from ACC1 and word A+1 live on the bus.
        ld_pair = mis_q ? {mem_rdata, word0_q} : {32'b0, mem_rdata};
        ld_word = 32'(ld_pair >> {off_q, 3'b000});
`else
        lane_lo = wdata_q << {off_q, 3'b000};
        we_lo   = mask4 << off_q;
        ld_word = mem_rdata >> {off_q, 3'b000};
`endif
        unique case (size_q)
            2'b00:   ld_ext = {{24{ld_word[7] & ~uns_q}}, ld_word[7:0]};
            2'b01:   ld_ext = {{16{ld_word[15] & ~uns_q}}, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        uns_d     = uns_q;
        size_d    = size_q;
        off_d     = off_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef MISALIGN_SPLIT_EN
        mis_d     = mis_q;
        word0_d   = word0_q;
`endif
        err_d     = 1'b0;
        rdata_d   = 32'b0;
        mem_en    = 1'b0;
        mem_we    = 4'b0;
        mem_addr  = '0;
        mem_wdata = 32'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    addr_d  = req_addr[ADDR_WIDTH+1:2];
                    wdata_d = req_wdata;
`ifdef MISALIGN_SPLIT_EN
                    mis_d   = req_mis;
`endif
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                mem_en    = 1'b1;
                mem_addr  = addr_q;
                mem_we    = we_q ? we_lo : 4'b0;
                mem_wdata = lane_lo;
`ifdef MISALIGN_SPLIT_EN
                if (mis_q) state_d = ACC1;
                else state_d = we_q ? RESP : WAIT;
`else
                state_d   = we_q ? RESP : WAIT;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            ACC1: begin
                mem_en    = 1'b1;
                mem_addr  = addr_q + ADDR_WIDTH'(1);
                mem_we    = we_q ? we_hi : 4'b0;
                mem_wdata = lane_hi;
                word0_d   = mem_rdata;
                state_d   = we_q ? RESP : WAIT;
            end
`endif
            WAIT: begin
                rdata_d = ld_ext;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b0;
            off_q   <= 2'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
`ifdef MISALIGN_SPLIT_EN
            mis_q   <= 1'b0;
            word0_q <= 32'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_SPLIT_EN
            mis_q   <= mis_d;
            word0_q <= word0_d;
`endif
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors with a queue scoreboard.
// Expectations follow whether MISALIGN_SPLIT_EN is defined.
module tb_load_store_unit;
    localparam int AW = 14;

    typedef struct {
        int          t;
        logic        err;
        logic [31:0] rd;
        int          nen;
        logic        ca;
        int          a0;
        int          a1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_a;
    logic [31:0]   pl_d;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    exp_t exp_q[$];
    int   alog[$];

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_we == 4'b0) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(int lat, logic err, logic [31:0] rd, int nen);
        exp_t e;
        e.t = lat; e.err = err; e.rd = rd; e.nen = nen;
        e.ca = 1'b0; e.a0 = 0; e.a1 = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            en_cnt = 0;
            alog.delete();
        end else begin
            if (mem_en) begin
                en_cnt++;
                alog.push_back(int'(mem_addr));
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_cycle", cyc, e.t);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_rdata", rsp_rdata, e.rd);
                    chk("mem_en_count", en_cnt, e.nen);
                    if (e.ca) begin
                        chk("addr_log_len", alog.size(), 2);
                        if (alog.size() >= 2) begin
                            chk("mem_addr_first", alog[0], e.a0);
                            chk("mem_addr_second", alog[1], e.a1);
                        end
                    end
                end
                en_cnt = 0;
                alog.delete();
            end
        end
    end

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = AW'(a); pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_before_issue", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = d;
        e.t = cyc + e.t;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_size = ~sz;
        req_unsigned = ~uns; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        chk("ready_low_after_accept", req_ready, 0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b0;
        req_unsigned = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;
        pl_en = 1'b0; pl_a = '0; pl_d = 32'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_outs", {rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we}, 0);
        chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        preload(0, 32'h8899_AABB);
        issue(0, 2'b00, 0, 32'h1, 0, mk(3, 0, 32'hFFFF_FFAA, 1));
        issue(0, 2'b00, 1, 32'h1, 0, mk(3, 0, 32'h0000_00AA, 1));
        issue(0, 2'b01, 0, 32'h2, 0, mk(3, 0, 32'hFFFF_8899, 1));
        issue(0, 2'b01, 1, 32'h2, 0, mk(3, 0, 32'h0000_8899, 1));
        issue(0, 2'b10, 1, 32'h0, 0, mk(3, 0, 32'h8899_AABB, 1));

        preload(1, 32'h1122_3344);
`ifdef MISALIGN_SPLIT_EN
        issue(0, 2'b01, 0, 32'h3, 0, mk(4, 0, 32'h0000_4488, 2));
`else
        issue(0, 2'b01, 0, 32'h3, 0, mk(1, 1, 32'h0, 0));
`endif

        preload(1, 32'h0);
        preload(2, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        issue(1, 2'b10, 0, 32'h6, 32'h1122_3344, mk(3, 0, 32'h0, 2));
        chk("sw_split_word1", mem[1], 32'h3344_0000);
        chk("sw_split_word2", mem[2], 32'h0000_1122);
`else
        issue(1, 2'b10, 0, 32'h6, 32'h1122_3344, mk(1, 1, 32'h0, 0));
        chk("sw_err_word1", mem[1], 32'h0);
        chk("sw_err_word2", mem[2], 32'h0);
`endif

        preload(7, 32'h0102_0304);
        issue(1, 2'b00, 0, 32'h1F, 32'hAABB_CCDD, mk(2, 0, 32'h0, 1));
        chk("sb_byte3", mem[7], 32'hDD02_0304);
        preload(8, 32'h1111_1111);
        issue(1, 2'b01, 0, 32'h22, 32'h0000_BEEF, mk(2, 0, 32'h0, 1));
        chk("sh_upper", mem[8], 32'hBEEF_1111);
        issue(0, 2'b10, 1, 32'hF000_001C, 0, mk(3, 0, 32'hDD02_0304, 1));
        issue(0, 2'b00, 0, 32'h1D, 0, mk(3, 0, 32'h0000_0003, 1));

        preload(16383, 32'hDDCC_BBAA);
        preload(0, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        e = mk(4, 0, 32'h0000_DDCC, 2);
        e.ca = 1'b1; e.a0 = 16383; e.a1 = 0;
`else
        e = mk(1, 1, 32'h0, 0);
`endif
        issue(0, 2'b10, 0, 32'h0000_FFFE, 0, e);
        issue(0, 2'b11, 0, 32'h10, 0, mk(1, 1, 32'h0, 0));
        issue(1, 2'b11, 0, 32'h10, 32'h1234_5678, mk(1, 1, 32'h0, 0));

        preload(1, 32'h0);
        preload(2, 32'h0);
        @(negedge clk);
        chk("ready_before_midop", req_ready, 1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        req_addr = 32'h6;
`else
        req_addr = 32'h24;
`endif
        req_wdata = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        @(negedge clk);
`endif
        chk("midop_active", mem_en, 1);
        rst = 1'b0;
        #1;
        chk("midop_rst_ctrl", {req_ready, rsp_valid, rsp_err, mem_en, mem_we, mem_addr}, 0);
        chk("midop_rst_data", {rsp_rdata, mem_wdata}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midop_ready_after_rst", req_ready, 1);
        issue(0, 2'b10, 0, 32'h1C, 0, mk(3, 0, 32'hDD02_0304, 1));

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
